// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine keypad front end.
// Key codes are row_idx*4 + col_idx as produced by keypad_scanner.
package vend_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HOLD      = 2'd2,
        DEB_REL   = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [1:0] idx;
        logic       single;
        logic       idle;
        logic       multi;
    } oh0_info_t;

    localparam logic [KEY_W-1:0] KEY_1      = 4'd0;
    localparam logic [KEY_W-1:0] KEY_2      = 4'd1;
    localparam logic [KEY_W-1:0] KEY_3      = 4'd2;
    localparam logic [KEY_W-1:0] KEY_4      = 4'd4;
    localparam logic [KEY_W-1:0] KEY_5      = 4'd5;
    localparam logic [KEY_W-1:0] KEY_6      = 4'd6;
    localparam logic [KEY_W-1:0] KEY_7      = 4'd8;
    localparam logic [KEY_W-1:0] KEY_8      = 4'd9;
    localparam logic [KEY_W-1:0] KEY_9      = 4'd10;
    localparam logic [KEY_W-1:0] KEY_BACK   = 4'd12;
    localparam logic [KEY_W-1:0] KEY_0      = 4'd13;
    localparam logic [KEY_W-1:0] KEY_ENSURE = 4'd14;

endpackage

// File: rtl/onehot0_index.sv
// Classifies a 4-bit active-low one-hot vector: index of the low bit
// plus single / idle / multi flags (exactly one flag is ever set).
module onehot0_index
    import vend_pkg::*;
(
    input  logic [3:0] vec,
    output oh0_info_t  info
);

    always_comb begin
        info = '0;
        case (vec)
            4'b1110: begin info.idx = 2'd0; info.single = 1'b1; end
            4'b1101: begin info.idx = 2'd1; info.single = 1'b1; end
            4'b1011: begin info.idx = 2'd2; info.single = 1'b1; end
            4'b0111: begin info.idx = 2'd3; info.single = 1'b1; end
            4'b1111: info.idle = 1'b1;
            default: info.multi = 1'b1;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, press/release
// debounce and one key_valid pulse per accepted press.
module keypad_scanner
    import vend_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(2);

    scan_state_t      state;
    logic [3:0]       row_m;
    logic [3:0]       row_s;
    logic [3:0]       cand_pat;
    logic [KEY_W-1:0] cand_code;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] deb_cnt;
    oh0_info_t        row_info;
    oh0_info_t        col_info;
    logic             scan_hit;
    logic             col_bad;

    onehot0_index u_row_idx (
        .vec  (row_s),
        .info (row_info)
    );

    onehot0_index u_col_idx (
        .vec  (col),
        .info (col_info)
    );

    // Row samples need two cycles after a column change to reflect it.
    always_comb begin
        scan_hit = 1'b0;
        unique case (1'b1)
            row_info.single: scan_hit = (div_cnt >= SETTLE) && col_info.single;
            row_info.idle,
            row_info.multi:  scan_hit = 1'b0;
        endcase
    end

    assign col_bad = col_info.idle | col_info.multi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            col       <= 4'b1110;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            cand_pat  <= 4'hF;
            cand_code <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (scan_hit) begin
                        cand_pat  <= row_s;
                        cand_code <= {row_info.idx, col_info.idx};
                        deb_cnt   <= '0;
                        state     <= DEB_PRESS;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        // A corrupted drive pattern restarts at column 0.
                        col <= col_bad ? 4'b1110 : {col[2:0], col[3]};
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (row_s != cand_pat) begin
                        div_cnt <= '0;
                        state   <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_code  <= cand_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (row_info.idle) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (!row_info.idle) begin
                        deb_cnt <= '0;
                        state   <= HOLD;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        div_cnt  <= '0;
                        state    <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomised bench for keypad_scanner: a physical keypad
// matrix drives the rows and a behavioural model predicts every output.
module tb_keypad_scanner;
    import vend_pkg::*;

    localparam int SD      = 4;
    localparam int DC      = 8;
    localparam int LAT_MAX = 2 + 4 * SD + DC + 1;

    localparam int P_SCAN  = 0;
    localparam int P_PRESS = 1;
    localparam int P_HOLD  = 2;
    localparam int P_REL   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       row;
    logic [3:0]       col;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_held;
    logic [15:0]      keys = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    int last_code = 0;
    bit prev_v   = 1'b0;

    keypad_scanner #(
        .SCAN_DIV   (SD),
        .DEB_CYCLES (DC),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++)
            if (keys[k] && !col[k[1:0]]) row[k[3:2]] = 1'b0;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int zeros(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) n++;
        return n;
    endfunction

    function automatic int pos0(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] colpat(input int i);
        logic [3:0] p;
        p = 4'hF;
        p[i[1:0]] = 1'b0;
        return p;
    endfunction

    // Reference model, in terms of phases, column index and run lengths.
    int         m_ph, m_col, m_div, m_deb, m_code, m_pend;
    logic [3:0] m_s1, m_s2, m_cand, m_rs;
    bit         m_valid, m_held;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_ph = P_SCAN; m_col = 0; m_div = 0; m_deb = 0;
            m_code = 0; m_pend = 0; m_valid = 0; m_held = 0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_cand = 4'hF;
        end else begin
            m_rs = m_s2;
            m_valid = 0;
            case (m_ph)
                P_SCAN:
                    if (zeros(m_rs) == 1 && m_div >= 2) begin
                        m_cand = m_rs;
                        m_pend = pos0(m_rs) * 4 + m_col;
                        m_deb = 0;
                        m_ph = P_PRESS;
                    end else if (m_div == SD - 1) begin
                        m_div = 0;
                        m_col = (m_col + 1) % 4;
                    end else m_div++;
                P_PRESS:
                    if (m_rs != m_cand) begin
                        m_ph = P_SCAN;
                        m_div = 0;
                    end else if (m_deb == DC - 1) begin
                        m_code = m_pend; m_valid = 1; m_held = 1;
                        m_ph = P_HOLD;
                    end else m_deb++;
                P_HOLD:
                    if (m_rs == 4'hF) begin
                        m_deb = 0;
                        m_ph = P_REL;
                    end
                P_REL:
                    if (m_rs != 4'hF) begin
                        m_deb = 0;
                        m_ph = P_HOLD;
                    end else if (m_deb == DC - 1) begin
                        m_held = 0; m_div = 0;
                        m_ph = P_SCAN;
                    end else m_deb++;
                default: ;
            endcase
            m_s2 = m_s1;
            m_s1 = row;
        end
    end

    initial forever begin
        @(negedge clk);
        check("col", col, colpat(m_col));
        check("key_valid", key_valid, m_valid);
        check("key_held", key_held, m_held);
        check("key_code", key_code, m_code);
        if (key_valid) begin
            check("valid_gap", prev_v, 0);
            n_pulse++;
            last_code = key_code;
        end
        prev_v = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int  p0;
    int  lat;
    bit  hit;

    initial begin
        #1 rst = 1'b0;
        tick(3);
        check("rst_col", col, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        rst = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            tick(1);
            check("idle_rotate", col, colpat((i / 4) % 4));
        end
        tick(24);
        check("idle_no_pulse", n_pulse, 0);

        p0 = n_pulse;
        lat = -1;
        keys = 16'(1) << 9;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (key_valid && lat < 0) lat = i;
        end
        check("latency_ok", int'(lat > 0 && lat <= LAT_MAX), 1);
        check("k9_pulses", n_pulse - p0, 1);
        check("k9_code", last_code, 9);
        check("k9_col_frozen", col, 4'b1101);
        check("k9_held", key_held, 1);
        keys = '0;
        tick(10);
        check("rel_held_still", key_held, 1);
        tick(1);
        check("rel_held_drop", key_held, 0);
        tick(4);
        check("rel_scan_resume", col, 4'b1011);

        p0 = n_pulse;
        repeat (4) begin
            keys = 16'(1) << 9;
            tick(5);
            keys = '0;
            tick(2);
        end
        check("bounce_no_pulse", n_pulse - p0, 0);
        keys = 16'(1) << 9;
        tick(30);
        check("bounce_then_pulse", n_pulse - p0, 1);
        check("bounce_code", last_code, 9);
        keys = '0;
        tick(20);

        p0 = n_pulse;
        keys = 16'h0011;
        tick(40);
        check("multi_no_pulse", n_pulse - p0, 0);
        keys[15] = 1'b1;
        tick(30);
        check("c3_pulses", n_pulse - p0, 1);
        check("c3_code", last_code, 15);
        keys = '0;
        tick(20);

        p0 = n_pulse;
        keys = 16'h0001;
        tick(30);
        check("k0_pulses", n_pulse - p0, 1);
        check("k0_code", last_code, 0);
        repeat (3) begin
            keys = '0;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                check("glitch_held", key_held, 1);
            end
            keys = 16'h0001;
            for (int i = 0; i < 10; i++) begin
                tick(1);
                check("glitch_held", key_held, 1);
            end
        end
        keys = '0;
        tick(20);
        check("glitch_one_pulse", n_pulse - p0, 1);
        check("glitch_released", key_held, 0);

        p0 = n_pulse;
        hit = 0;
        keys = 16'(1) << 6;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick(1);
            if (m_ph == P_PRESS && m_deb == 5) hit = 1;
        end
        check("deb5_reached", hit, 1);
        rst = 1'b0;
        #1;
        check("midrst_col", col, 4'b1110);
        check("midrst_held", key_held, 0);
        check("midrst_valid", key_valid, 0);
        tick(2);
        rst = 1'b1;
        tick(DC + 1);
        check("midrst_no_pulse", n_pulse - p0, 0);
        for (int i = 0; i < LAT_MAX + 5 && n_pulse == p0; i++) tick(1);
        check("midrst_fresh", n_pulse - p0, 1);
        check("midrst_code", last_code, 6);
        keys = '0;
        tick(20);

        repeat (40) begin
            keys = 16'(1) << $urandom_range(15);
            if ($urandom_range(3) == 0) keys[$urandom_range(15)] = 1'b1;
            tick($urandom_range(40, 1));
            keys = '0;
            tick($urandom_range(25, 1));
        end
        tick(30);
        check("final_held", key_held, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
